// File: rtl/fft_pkg.sv
// Shared constants and helpers for the single-path FFT delay/commutator buffers.
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 16;
  localparam int unsigned FFT_DEPTH = 16;

  // Map a requested delay onto the usable range 1..depth.
  function automatic int unsigned clamp_delay(input int unsigned delay, input int unsigned depth);
    if (delay == 0)
      return 1;
    else if (delay > depth)
      return depth;
    else
      return delay;
  endfunction

endpackage

// File: rtl/var_delay_reg_if.sv
// Stream/control bundle for var_delay_reg: control and sample in, tapped sample out.
interface var_delay_reg_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic             en;
  logic             clr;
  logic [DW-1:0]    delay;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             primed;

  modport master (
    output en, clr, delay, in_valid, in_data,
    input  out_data, out_valid, primed
  );

  modport slave (
    input  en, clr, delay, in_valid, in_data,
    output out_data, out_valid, primed
  );
endinterface

// File: rtl/var_delay_reg_dly_stage.sv
// One delay-line cell: enabled data+valid register, async reset, sync clear.
module dly_stage #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= RST_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_data  <= RST_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q_data  <= d_data;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/var_delay_reg.sv
// Runtime-selectable delay line: DEPTH enabled stages, tap mux and fill counter.
module var_delay_reg
  import fft_pkg::*;
#(
  parameter int unsigned      WIDTH   = FFT_WIDTH,
  parameter int unsigned      DEPTH   = FFT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  var_delay_reg_if.slave bus
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] s [DEPTH+1];
  logic             v [DEPTH+1];
  logic [DW-1:0]    d_eff;
  logic [DW-1:0]    d_prev;
  logic [DW-1:0]    cnt;
  logic [WIDTH-1:0] tap_data;
  logic             tap_valid;

  assign s[0] = bus.in_data;
  assign v[0] = bus.in_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    dly_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .clr     (bus.clr),
      .d_data  (s[k-1]),
      .d_valid (v[k-1]),
      .q_data  (s[k]),
      .q_valid (v[k])
    );
  end

  assign d_eff = DW'(clamp_delay(32'(bus.delay), DEPTH));

  // A delay change restarts the fill count; an enabled edge on the change already counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      d_prev <= DW'(1);
    end else if (bus.clr) begin
      cnt    <= '0;
      d_prev <= d_eff;
    end else if (d_eff != d_prev) begin
      d_prev <= d_eff;
      cnt    <= bus.en ? DW'(1) : '0;
    end else if (bus.en && (cnt != DW'(DEPTH))) begin
      cnt <= cnt + DW'(1);
    end
  end

  always_comb begin
    tap_data  = RST_VAL;
    tap_valid = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (d_eff == DW'(k)) begin
        tap_data  = s[k];
        tap_valid = v[k];
      end
    end
  end

  assign bus.out_data  = tap_data;
  assign bus.out_valid = tap_valid;
  assign bus.primed    = (cnt >= d_eff) && (d_eff == d_prev);

endmodule

// File: tb/tb_var_delay_reg.sv
// Directed, table-driven bench for var_delay_reg (WIDTH=16, DEPTH=16, RST_VAL=0x0BAD).
module tb_var_delay_reg;
  import fft_pkg::*;

  localparam int unsigned   W  = 16;
  localparam int unsigned   D  = 16;
  localparam logic [15:0]   RV = 16'h0BAD;

  typedef struct {
    logic        en;
    logic        clr;
    logic [4:0]  dly;
    logic        iv;
    logic [15:0] din;
    logic [15:0] xd;
    logic        xv;
    logic        xp;
  } vec_t;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;
  vec_t tbl [19];

  var_delay_reg_if #(.WIDTH(W), .DEPTH(D)) bus ();

  var_delay_reg #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [15:0] xd, input logic xv, input logic xp);
    chk({nm, ".data"},   bus.out_data,       xd);
    chk({nm, ".valid"},  16'(bus.out_valid), 16'(xv));
    chk({nm, ".primed"}, 16'(bus.primed),    16'(xp));
  endtask

  initial begin
    nchk = 0;
    nerr = 0;

    // delay 4 streaming from reset, with one invalid sample and one stall
    tbl[0]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0001, RV,       1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0002, RV,       1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0003, RV,       1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0004, 16'h0001, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0005, 16'h0002, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 5'd4, 1'b0, 16'h0006, 16'h0003, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 5'd4, 1'b1, 16'h0007, 16'h0003, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0008, 16'h0004, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h0009, 16'h0005, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 5'd4, 1'b1, 16'h000A, 16'h0006, 1'b0, 1'b1};
    // clear, then delay 3 with en toggling
    tbl[10] = '{1'b1, 1'b1, 5'd3, 1'b1, 16'h0077, RV,       1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 5'd3, 1'b1, 16'h00A5, RV,       1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd3, 1'b1, 16'h0011, RV,       1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 5'd3, 1'b1, 16'h0022, RV,       1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'd3, 1'b1, 16'h0033, RV,       1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 5'd3, 1'b1, 16'h0044, 16'h00A5, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 5'd3, 1'b1, 16'h0055, 16'h00A5, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 5'd3, 1'b1, 16'h0066, 16'h0022, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 5'd3, 1'b1, 16'h0077, 16'h0022, 1'b1, 1'b1};

    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.delay    = 5'd4;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #11;
    chk3("reset", RV, 1'b0, 1'b0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus.en       = tbl[i].en;
      bus.clr      = tbl[i].clr;
      bus.delay    = tbl[i].dly;
      bus.in_valid = tbl[i].iv;
      bus.in_data  = tbl[i].din;
      step();
      chk3($sformatf("vec%0d", i), tbl[i].xd, tbl[i].xv, tbl[i].xp);
    end

    // delay 8 stream, then switch to 2 mid-stream
    bus.clr = 1'b1; bus.en = 1'b0; bus.delay = 5'd8;
    step();
    bus.clr = 1'b0; bus.en = 1'b1; bus.in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 16'h0100 + 16'(i);
      step();
    end
    chk3("d8_full", 16'h0103, 1'b1, 1'b1);
    bus.delay = 5'd2;
    #1;
    chk3("d2_switch", 16'h0109, 1'b1, 1'b0);
    bus.in_data = 16'h010B;
    step();
    chk3("d2_edge1", 16'h010A, 1'b1, 1'b0);
    bus.in_data = 16'h010C;
    step();
    chk3("d2_edge2", 16'h010B, 1'b1, 1'b1);

    // delay 0 behaves as 1
    bus.clr = 1'b1; bus.en = 1'b0; bus.delay = 5'd0;
    step();
    bus.clr = 1'b0; bus.en = 1'b1; bus.in_data = 16'h00F1;
    step();
    chk3("d0_lat1", 16'h00F1, 1'b1, 1'b1);

    // delay 21 clamps to 16; run long enough to cover counter saturation
    bus.clr = 1'b1; bus.delay = 5'd21;
    step();
    bus.clr = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      bus.in_data = 16'h0200 + 16'(i);
      step();
      if (i == 15)
        chk3("d21_pre", RV, 1'b0, 1'b0);
      if (i >= 16)
        chk3($sformatf("d21_e%0d", i), 16'h0200 + 16'(i - 15), 1'b1, 1'b1);
    end

    // clr together with en while full: sample dropped
    bus.clr = 1'b1; bus.en = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h3333; bus.delay = 5'd1;
    step();
    chk3("clr_en_s1", RV, 1'b0, 1'b0);
    bus.clr = 1'b0; bus.en = 1'b0; bus.delay = 5'd16;
    #1;
    chk3("clr_en_s16", RV, 1'b0, 1'b0);

    // async reset between edges
    bus.clr = 1'b1; bus.delay = 5'd2;
    step();
    bus.clr = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 16'h0400 + 16'(i);
      step();
    end
    chk3("pre_rst", 16'h0402, 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk3("async_rst", RV, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    bus.in_data = 16'h0501;
    step();
    chk3("post_rst1", RV, 1'b0, 1'b0);
    bus.in_data = 16'h0502;
    step();
    chk3("post_rst2", 16'h0501, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/var_delay_reg.md
Name: var_delay_reg

Overview:
- Parametrised, runtime-selectable delay line: a chain of enabled, asynchronously-reset W-bit registers with a per-stage valid bit and a tap multiplexer.
- Generalises the single enabled register to WIDTH bits, DEPTH stages, a selectable tap and stream-valid tracking.
- Used as the delay/commutator buffer in the single-path FFT pipeline, where each butterfly stage needs a different delay: 16, 8, 4, 2 or 1 for N=32.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 16, number of stages and maximum delay (>=2).
- RST_VAL, 0, value loaded into every data stage on reset and clear.
- DW (localparam), $clog2(DEPTH)+1, width of the delay select.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  shift enable; when low, all state holds (stall).
- clr  in  1  synchronous clear; has priority over en.
- delay  in  DW  requested delay in enabled cycles.
- in_valid  in  1  qualifies in_data.
- in_data  in  WIDTH  sample entering stage 1.
- out_data  out  WIDTH  contents of stage d_eff.
- out_valid  out  1  valid bit of stage d_eff.
- primed  out  1  high once at least d_eff enabled shifts have occurred since the last reset, clear or delay change.

Behaviour:
- Effective delay d_eff: delay==0 maps to 1; delay>DEPTH maps to DEPTH; otherwise d_eff=delay. The clamp is combinational.
- State:
  - Data stages s[1..DEPTH] and valid bits v[1..DEPTH].
  - Fill counter cnt, width DW, saturating at DEPTH.
  - Registered d_prev, holding the last d_eff.
- rst asserted (asynchronous, immediate):
  - s[k]=RST_VAL and v[k]=0 for all k.
  - cnt=0; d_prev=1.
  - Outputs therefore read out_data=RST_VAL, out_valid=0, primed=0.
- Edge with clr=1, regardless of en:
  - All s[k]=RST_VAL, all v[k]=0.
  - cnt=0; d_prev<=d_eff.
- Edge with clr=0, en=1:
  - s[1]<=in_data and v[1]<=in_valid.
  - s[k]<=s[k-1] and v[k]<=v[k-1] for k=2..DEPTH.
  - cnt<=min(cnt+1, DEPTH).
  - Exception: if d_eff != d_prev, cnt<=1 (this shift counts) and d_prev<=d_eff.
- Edge with clr=0, en=0:
  - Stages, valid bits and cnt hold.
  - If d_eff != d_prev: cnt<=0 and d_prev<=d_eff.
- Outputs are combinational from registers plus d_eff:
  - out_data=s[d_eff], out_valid=v[d_eff], primed=(cnt>=d_eff) && (d_eff==d_prev).
- Latency: a sample presented at enabled edge n is visible on out_data after enabled edge n+d_eff-1, i.e. d_eff enabled edges after it was presented. Stalled cycles do not count.
- Delay change mid-stream:
  - The tap moves immediately; data already in the stages is not flushed.
  - primed drops the same cycle and re-asserts after d_eff further enabled shifts.
- Saturation: cnt never exceeds DEPTH and never wraps.
- Reset mid-operation: all in-flight samples are discarded; no partial shift is visible.
- Simultaneous clr and en: clr wins, and the sample on in_data is dropped.

Decomposition:
- Shared package fft_pkg:
  - Default WIDTH/DEPTH constants for the N=32 pipeline.
  - The function clamp_delay(delay, DEPTH) returning d_eff, reused by the commutator controller.
- One sub-module, dly_stage: a WIDTH+1-bit enabled register (data plus valid) with async reset to RST_VAL/0 and a sync clear.
- var_delay_reg instantiates DEPTH dly_stage cells via generate and adds the tap mux plus the fill counter.

Test Plan:
1. Reset release, delay=4, en=1, in_data=1,2,3,... with in_valid=1 → out_data=RST_VAL and out_valid=0 until the 4th enabled edge, then out_data=1,2,3... and primed=1 from that edge.
2. delay=3, en toggled 1,0,1,0,... with in_data=0xA5 on the first edge → 0xA5 appears on out_data only after the 3rd enabled edge; held values are unchanged on every en=0 cycle.
3. Stream with delay=8, switch to delay=2 mid-stream → out_data immediately shows s[2]; primed falls that cycle and rises after 2 further enabled edges.
4. delay=0 and delay=DEPTH+5 (DEPTH=16) → behave as delay 1 and 16 respectively; check out_data latency of 1 and 16.
5. clr=1 together with en=1 while full → all outputs RST_VAL/0 next cycle, primed=0, and the input sample is dropped.
6. rst asserted between clock edges mid-stream → outputs go to RST_VAL/0 without waiting for a clk edge; after release the counter restarts from 0.
